video_test_pattern_source: RTL
==============================

# video_test_pattern_source

Programmable test-pattern generator feeding the video generator pipeline's generator interface. It takes the pixel position and data-enable strobe the generator source emits and returns 8-bit R/G/B plus a delayed data-enable after a fixed 3-cycle latency. It provides solid, colour-bar, checkerboard, gradient, scrolling and border patterns for scaler bring-up. All pattern configuration is latched at frame start so a pattern never tears mid-frame.

## Interface
- HACTIVE_BITS, 11, horizontal position width
- VACTIVE_BITS, 11, vertical position width
- scalerClock  in  1  sole clock; all logic is on the rising edge
- reset  in  1  asynchronous, active-low; 0 = reset asserted
- hPos  in  HACTIVE_BITS  requested pixel column
- vPos  in  VACTIVE_BITS  requested pixel row
- dataEnable  in  1  hPos/vPos valid this cycle
- patternSelect  in  3  0 solid, 1 bars, 2 checker, 3 h-gradient, 4 v-gradient, 5 scroll, 6 border, 7 black
- solidColor  in  24  {R,G,B} for pattern 0 and checker foreground
- barShift  in  4  colour-bar width = 2^barShift columns
- checkShift  in  4  checker square side = 2^checkShift pixels
- sourceColumns  in  HACTIVE_BITS  frame width, used by border
- sourceRows  in  VACTIVE_BITS  frame height, used by border
- r, g, b  out  8 each  pattern colour
- dataEnableDelayed  out  1  dataEnable delayed exactly 3 cycles
- frameCount  out  8  frames started since reset, wraps 255 -> 0

## Operation
- Accepted pixel: dataEnable=1 in a cycle. Frame-start event: an accepted pixel with hPos=0 and vPos=0.
- Active config (patternSelect, solidColor, barShift, checkShift, sourceColumns, sourceRows) is copied from the inputs on every frame-start event; otherwise it holds. A frame-start pixel uses the newly latched values.
- frameCount increments on a frame-start event only when prevVPos != 0. prevVPos updates to vPos on every accepted pixel. Repeated (0,0) requests within a frame therefore count once.
- Patterns, all computed from active config:
  - 0: solidColor.
  - 1: palette[(hPos >> barShift) & 7]. Palette order is white, yellow, cyan, green, magenta, red, blue, black, with each component 8'hFF or 8'h00.
  - 2: solidColor if ((hPos>>checkShift) ^ (vPos>>checkShift)) bit 0 = 0, else 24'h000000.
  - 3: R=G=B=hPos[7:0].
  - 4: R=G=B=vPos[7:0].
  - 5: R=(hPos+frameCount)[7:0], G=(vPos+frameCount)[7:0], B=(hPos+vPos)[7:0]. Sums are truncated to 8 bits.
  - 6: 24'hFFFFFF when hPos=0, hPos=sourceColumns-1, vPos=0 or vPos=sourceRows-1; else black. Out-of-range positions are black.
  - 7: black.
- When the stage-3 data-enable is 0, r/g/b are forced to 0.

## Timing
- Pipeline: S1 registers inputs and updates config/counters; S2 computes pattern terms; S3 muxes and registers the outputs.
- Latency is fixed at 3: an input at edge n appears on r/g/b/dataEnableDelayed after edge n+3.
- Throughput is 1 pixel/cycle with no stall path; back-to-back and gapped dataEnable are both legal.
- frameCount uses its pre-increment value for the frame-start pixel's own pattern-5 colour and is visible on the port one cycle after S1.
- Reset values: r=g=b=0, dataEnableDelayed=0, frameCount=0, prevVPos=0, all active config=0 (solid black), all pipeline valids=0.
- Reset asserted mid-operation clears all pipeline stages immediately; no partial pixel emerges after release.
- Config inputs that change without a frame start have no effect on output.

## Structure
- Shared package video_test_pattern_pkg holds the pattern-select localparams (PATTERN_SOLID..PATTERN_BLACK), the 24-bit colour constants, and the bar palette width.
- Sub-module video_test_pattern_bar_palette: an 8-entry combinational palette indexed by 3 bits, returning 24 bits.
- The top level holds the config latch, frame counter and 3-stage pipeline.

## Test plan
- **Reset:** hold reset=0 with dataEnable=1 -> all outputs 0. Release, then feed pattern 0 with solidColor=24'h123456 and (0,0) -> r,g,b = 12,34,56 and dataEnableDelayed=1 exactly 3 cycles later.
- **Colour bars:** pattern 1, barShift=4, sweep hPos 0..127 on row 5 -> colour changes every 16 columns; hPos 32..47 is cyan (00,FF,FF); hPos 112 is black.
- **Config hold:** change patternSelect 0->3 mid-frame at vPos=7 -> output stays solid until the next (0,0). From then on R=G=B=hPos[7:0], with hPos=300 giving 8'h2C.
- **Frame counter:** issue (0,0) three times in a frame, then vPos 1..3, then (0,0) -> frameCount increments by exactly 1 per frame. After 256 frames it wraps to 0. Pattern 5 at (0,0) with frameCount=10 gives R=10.
- **Border:** pattern 6, sourceColumns=320, sourceRows=240 -> (319,100) and (10,239) are white; (318,238) and (400,10) are black.
- **Gaps and mid-stream reset:** alternate dataEnable 1/0 -> dataEnableDelayed shows the same 1/0 pattern shifted 3 cycles, with r/g/b=0 in the gaps. Assert reset mid-stream -> outputs drop to 0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/video_test_pattern_pkg.sv
// rtl/video_test_pattern_pkg.sv - shared pattern codes, colour constants and config type for the test-pattern source
package video_test_pattern_pkg;

    localparam logic [2:0] PATTERN_SOLID   = 3'd0;
    localparam logic [2:0] PATTERN_BARS    = 3'd1;
    localparam logic [2:0] PATTERN_CHECKER = 3'd2;
    localparam logic [2:0] PATTERN_HGRAD   = 3'd3;
    localparam logic [2:0] PATTERN_VGRAD   = 3'd4;
    localparam logic [2:0] PATTERN_SCROLL  = 3'd5;
    localparam logic [2:0] PATTERN_BORDER  = 3'd6;
    localparam logic [2:0] PATTERN_BLACK   = 3'd7;

    localparam int COLOR_BITS       = 24;
    localparam int BAR_PALETTE_BITS = 3;

    localparam logic [COLOR_BITS-1:0] COLOR_WHITE   = 24'hFFFFFF;
    localparam logic [COLOR_BITS-1:0] COLOR_YELLOW  = 24'hFFFF00;
    localparam logic [COLOR_BITS-1:0] COLOR_CYAN    = 24'h00FFFF;
    localparam logic [COLOR_BITS-1:0] COLOR_GREEN   = 24'h00FF00;
    localparam logic [COLOR_BITS-1:0] COLOR_MAGENTA = 24'hFF00FF;
    localparam logic [COLOR_BITS-1:0] COLOR_RED     = 24'hFF0000;
    localparam logic [COLOR_BITS-1:0] COLOR_BLUE    = 24'h0000FF;
    localparam logic [COLOR_BITS-1:0] COLOR_BLACK   = 24'h000000;

    // Position-independent part of the frame-latched configuration.
    typedef struct packed {
        logic [2:0]            pattern_select;
        logic [COLOR_BITS-1:0] solid_color;
        logic [3:0]            bar_shift;
        logic [3:0]            check_shift;
    } pattern_cfg_t;

    function automatic logic [COLOR_BITS-1:0] gray24(input logic [7:0] level);
        return {level, level, level};
    endfunction

endpackage

// File: rtl/video_test_pattern_bar_palette.sv
// rtl/video_test_pattern_bar_palette.sv - 8-entry combinational colour-bar palette
module video_test_pattern_bar_palette
    import video_test_pattern_pkg::*;
(
    input  logic [BAR_PALETTE_BITS-1:0] index,
    output logic [COLOR_BITS-1:0]       color
);

    always_comb begin
        color = COLOR_BLACK;
        case (index)
            3'd0:    color = COLOR_WHITE;
            3'd1:    color = COLOR_YELLOW;
            3'd2:    color = COLOR_CYAN;
            3'd3:    color = COLOR_GREEN;
            3'd4:    color = COLOR_MAGENTA;
            3'd5:    color = COLOR_RED;
            3'd6:    color = COLOR_BLUE;
            default: color = COLOR_BLACK;
        endcase
    end

endmodule

// File: rtl/video_test_pattern_source.sv
// rtl/video_test_pattern_source.sv - 3-stage programmable test-pattern generator with frame-latched config
module video_test_pattern_source
    import video_test_pattern_pkg::*;
#(
    parameter int HACTIVE_BITS = 11,
    parameter int VACTIVE_BITS = 11
) (
    input  logic                    scalerClock,
    input  logic                    reset,
    input  logic [HACTIVE_BITS-1:0] hPos,
    input  logic [VACTIVE_BITS-1:0] vPos,
    input  logic                    dataEnable,
    input  logic [2:0]              patternSelect,
    input  logic [COLOR_BITS-1:0]   solidColor,
    input  logic [3:0]              barShift,
    input  logic [3:0]              checkShift,
    input  logic [HACTIVE_BITS-1:0] sourceColumns,
    input  logic [VACTIVE_BITS-1:0] sourceRows,
    output logic [7:0]              r,
    output logic [7:0]              g,
    output logic [7:0]              b,
    output logic                    dataEnableDelayed,
    output logic [7:0]              frameCount
);

    localparam logic [HACTIVE_BITS-1:0] H_ONE = HACTIVE_BITS'(1);
    localparam logic [VACTIVE_BITS-1:0] V_ONE = VACTIVE_BITS'(1);

    logic frame_start;
    assign frame_start = dataEnable && (hPos == '0) && (vPos == '0);

    // Stage 1: input capture, config latch, frame counter.
    pattern_cfg_t            cfg;
    logic [HACTIVE_BITS-1:0] cfg_cols;
    logic [VACTIVE_BITS-1:0] cfg_rows;
    logic [VACTIVE_BITS-1:0] prev_v;
    logic                    s1_valid;
    logic [HACTIVE_BITS-1:0] s1_h;
    logic [VACTIVE_BITS-1:0] s1_v;
    logic [7:0]              s1_fc;

    always_ff @(posedge scalerClock or negedge reset) begin
        if (!reset) begin
            cfg        <= '0;
            cfg_cols   <= '0;
            cfg_rows   <= '0;
            prev_v     <= '0;
            frameCount <= '0;
            s1_valid   <= 1'b0;
            s1_h       <= '0;
            s1_v       <= '0;
            s1_fc      <= '0;
        end else begin
            s1_valid <= dataEnable;
            s1_h     <= hPos;
            s1_v     <= vPos;
            // Pre-increment count travels with the pixel so the frame-start pixel scrolls by the old value.
            s1_fc    <= frameCount;
            if (dataEnable) begin
                prev_v <= vPos;
            end
            if (frame_start) begin
                cfg.pattern_select <= patternSelect;
                cfg.solid_color    <= solidColor;
                cfg.bar_shift      <= barShift;
                cfg.check_shift    <= checkShift;
                cfg_cols           <= sourceColumns;
                cfg_rows           <= sourceRows;
                if (prev_v != '0) begin
                    frameCount <= frameCount + 8'd1;
                end
            end
        end
    end

    // Stage 2 terms; everything config-dependent is resolved here so a later
    // frame-start latch cannot disturb a pixel already in stage 3.
    logic [BAR_PALETTE_BITS-1:0] bar_index;
    logic [COLOR_BITS-1:0]       bar_color;
    logic                        check_odd;
    logic                        in_range;
    logic                        on_edge;
    logic [7:0]                  scroll_r;
    logic [7:0]                  scroll_g;
    logic [7:0]                  scroll_b;

    assign bar_index = BAR_PALETTE_BITS'(s1_h >> cfg.bar_shift);
    assign check_odd = 1'(s1_h >> cfg.check_shift) ^ 1'(s1_v >> cfg.check_shift);
    assign in_range  = (s1_h < cfg_cols) && (s1_v < cfg_rows);
    assign on_edge   = (s1_h == '0) || (s1_h == cfg_cols - H_ONE) ||
                       (s1_v == '0) || (s1_v == cfg_rows - V_ONE);
    assign scroll_r  = s1_h[7:0] + s1_fc;
    assign scroll_g  = s1_v[7:0] + s1_fc;
    assign scroll_b  = s1_h[7:0] + s1_v[7:0];

    video_test_pattern_bar_palette u_bar_palette (
        .index (bar_index),
        .color (bar_color)
    );

    logic                  s2_valid;
    logic [2:0]            s2_sel;
    logic [COLOR_BITS-1:0] s2_solid;
    logic [COLOR_BITS-1:0] s2_bar;
    logic                  s2_check_odd;
    logic [7:0]            s2_h8;
    logic [7:0]            s2_v8;
    logic [COLOR_BITS-1:0] s2_scroll;
    logic                  s2_border;

    always_ff @(posedge scalerClock or negedge reset) begin
        if (!reset) begin
            s2_valid     <= 1'b0;
            s2_sel       <= PATTERN_SOLID;
            s2_solid     <= COLOR_BLACK;
            s2_bar       <= COLOR_BLACK;
            s2_check_odd <= 1'b0;
            s2_h8        <= '0;
            s2_v8        <= '0;
            s2_scroll    <= COLOR_BLACK;
            s2_border    <= 1'b0;
        end else begin
            s2_valid     <= s1_valid;
            s2_sel       <= cfg.pattern_select;
            s2_solid     <= cfg.solid_color;
            s2_bar       <= bar_color;
            s2_check_odd <= check_odd;
            s2_h8        <= s1_h[7:0];
            s2_v8        <= s1_v[7:0];
            s2_scroll    <= {scroll_r, scroll_g, scroll_b};
            s2_border    <= in_range && on_edge;
        end
    end

    // Stage 3: pattern mux and output register.
    logic [COLOR_BITS-1:0] pattern_rgb;

    always_comb begin
        pattern_rgb = COLOR_BLACK;
        case (s2_sel)
            PATTERN_SOLID:   pattern_rgb = s2_solid;
            PATTERN_BARS:    pattern_rgb = s2_bar;
            PATTERN_CHECKER: pattern_rgb = s2_check_odd ? COLOR_BLACK : s2_solid;
            PATTERN_HGRAD:   pattern_rgb = gray24(s2_h8);
            PATTERN_VGRAD:   pattern_rgb = gray24(s2_v8);
            PATTERN_SCROLL:  pattern_rgb = s2_scroll;
            PATTERN_BORDER:  pattern_rgb = s2_border ? COLOR_WHITE : COLOR_BLACK;
            default:         pattern_rgb = COLOR_BLACK;
        endcase
    end

    always_ff @(posedge scalerClock or negedge reset) begin
        if (!reset) begin
            r                 <= '0;
            g                 <= '0;
            b                 <= '0;
            dataEnableDelayed <= 1'b0;
        end else begin
            dataEnableDelayed <= s2_valid;
            if (s2_valid) begin
                {r, g, b} <= pattern_rgb;
            end else begin
                {r, g, b} <= COLOR_BLACK;
            end
        end
    end

endmodule
